spi_slave_core: RTL and testbench

SPI target-side engine: the far end of the link driven by our SPI controller's baud rate generator. It oversamples the external sclk, ss_n and mosi in the PCLK domain, detects sclk edges according to cpol/cpha, and shifts a DATA_W-bit frame in from mosi while shifting a frame out on miso. It exposes valid/ready handshakes for TX load and RX unload toward the register/APB front end.

---
 rtl/spi_pkg.sv | 18 +
 rtl/spi_slave_core_if.sv | 36 +++
 rtl/spi_sync_edge.sv | 32 +++
 rtl/spi_slave_core.sv | 186 ++++++++++++++++++
 tb/tb_spi_slave_core.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions: mode encodings, default frame width and the
// target-side FSM state type used by the SPI controller, baud generator and target.
package spi_pkg;

  // Mode encoding is {cpol, cpha}
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  localparam int DEFAULT_DATA_W = 8;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_state_e;

endpackage

// File: rtl/spi_slave_core_if.sv
// Pin-level SPI signals plus TX/RX valid/ready handshakes of the SPI target core.
interface spi_slave_core_if #(
  parameter int DATA_W = spi_pkg::DEFAULT_DATA_W
);
  logic              cpol;
  logic              cpha;
  logic              lsbfe;
  logic              sclk_in;
  logic              ss_n_in;
  logic              mosi_in;
  logic              miso_out;
  logic              miso_oe;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              overrun;
  logic              frame_abort;
  logic              busy;

  modport slave (
    input  cpol, cpha, lsbfe, sclk_in, ss_n_in, mosi_in,
    input  tx_data, tx_valid, rx_ready,
    output miso_out, miso_oe, tx_ready, rx_data, rx_valid,
    output overrun, frame_abort, busy
  );

  modport master (
    output cpol, cpha, lsbfe, sclk_in, ss_n_in, mosi_in,
    output tx_data, tx_valid, rx_ready,
    input  miso_out, miso_oe, tx_ready, rx_data, rx_valid,
    input  overrun, frame_abort, busy
  );
endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin with single-cycle
// rise/fall pulses derived from the synchronized level.
module spi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic rst_val_i,
  input  logic d_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{rst_val_i}};
      prev_q <= rst_val_i;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync_o = sync_q[SYNC_STAGES-1];
  assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign fall_o = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/spi_slave_core.sv
// SPI target engine: oversamples sclk/ss_n/mosi in the PCLK domain, shifts a
// frame in on the sample edge and out on the shift edge, with TX/RX handshakes.
module spi_slave_core
  import spi_pkg::*;
#(
  parameter int              DATA_W      = DEFAULT_DATA_W,
  parameter int              SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] IDLE_TX   = '1
) (
  input logic             PCLK,
  input logic             PRESET,
  spi_slave_core_if.slave bus
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  logic sclk_rise, sclk_fall, sclk_level_unused;
  logic ss_sync, ss_rise, ss_fall;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic mosi_s;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
    .clk       (PCLK),
    .rst       (PRESET),
    .rst_val_i (bus.cpol),
    .d_i       (bus.sclk_in),
    .sync_o    (sclk_level_unused),
    .rise_o    (sclk_rise),
    .fall_o    (sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_ss_sync (
    .clk       (PCLK),
    .rst       (PRESET),
    .rst_val_i (1'b1),
    .d_i       (bus.ss_n_in),
    .sync_o    (ss_sync),
    .rise_o    (ss_rise),
    .fall_o    (ss_fall)
  );

  spi_state_e        state_q, state_d;
  logic              cpol_q, cpol_d, cpha_q, cpha_d, lsbfe_q, lsbfe_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rx_sh_q, rx_sh_d, tx_sh_q, tx_sh_d;
  logic [DATA_W-1:0] tx_buf_q, tx_buf_d, rx_data_q, rx_data_d;
  logic              tx_full_q, tx_full_d, rx_valid_q, rx_valid_d;
  logic              rx_done_q, rx_done_d, overrun_q, overrun_d, abort_q, abort_d;

  logic              lead_edge, trail_edge, sample_edge, shift_edge, tx_take;
  logic [DATA_W-1:0] load_src;

  assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
  assign lead_edge   = cpol_q ? sclk_fall : sclk_rise;
  assign trail_edge  = cpol_q ? sclk_rise : sclk_fall;
  assign sample_edge = cpha_q ? trail_edge : lead_edge;
  assign shift_edge  = cpha_q ? lead_edge : trail_edge;
  assign load_src    = tx_full_q ? tx_buf_q : IDLE_TX;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      mosi_sync_q <= '0;
      state_q     <= IDLE;
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      lsbfe_q     <= 1'b0;
      cnt_q       <= '0;
      rx_sh_q     <= '0;
      tx_sh_q     <= '0;
      tx_buf_q    <= '0;
      tx_full_q   <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      rx_done_q   <= 1'b0;
      overrun_q   <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi_in};
      state_q     <= state_d;
      cpol_q      <= cpol_d;
      cpha_q      <= cpha_d;
      lsbfe_q     <= lsbfe_d;
      cnt_q       <= cnt_d;
      rx_sh_q     <= rx_sh_d;
      tx_sh_q     <= tx_sh_d;
      tx_buf_q    <= tx_buf_d;
      tx_full_q   <= tx_full_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      rx_done_q   <= rx_done_d;
      overrun_q   <= overrun_d;
      abort_q     <= abort_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;
    lsbfe_d    = lsbfe_q;
    cnt_d      = cnt_q;
    rx_sh_d    = rx_sh_q;
    tx_sh_d    = tx_sh_q;
    tx_buf_d   = tx_buf_q;
    tx_full_d  = tx_full_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    rx_done_d  = 1'b0;
    overrun_d  = 1'b0;
    abort_d    = 1'b0;
    tx_take    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (ss_fall) begin
          state_d = ACTIVE;
          cpol_d  = bus.cpol;
          cpha_d  = bus.cpha;
          lsbfe_d = bus.lsbfe;
          cnt_d   = '0;
          rx_sh_d = '0;
          // With cpha=1 the first shift edge performs the load instead
          if (!bus.cpha) begin
            tx_sh_d = load_src;
            tx_take = 1'b1;
          end
        end
      end
      ACTIVE: begin
        if (ss_rise) begin
          state_d = IDLE;
          abort_d = (cnt_q != '0);
          cnt_d   = '0;
        end else begin
          if (sample_edge) begin
            rx_sh_d = lsbfe_q ? {mosi_s, rx_sh_q[DATA_W-1:1]}
                              : {rx_sh_q[DATA_W-2:0], mosi_s};
            if (cnt_q == CNT_LAST) begin
              cnt_d     = '0;
              rx_done_d = 1'b1;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          // A shift edge at count 0 is always a frame boundary in either cpha
          if (shift_edge) begin
            if (cnt_q == '0) begin
              tx_sh_d = load_src;
              tx_take = 1'b1;
            end else begin
              tx_sh_d = lsbfe_q ? {1'b0, tx_sh_q[DATA_W-1:1]}
                                : {tx_sh_q[DATA_W-2:0], 1'b0};
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (tx_take && tx_full_q) tx_full_d = 1'b0;
    if (bus.tx_valid && !tx_full_q) begin
      tx_buf_d  = bus.tx_data;
      tx_full_d = 1'b1;
    end

    if (rx_done_q) begin
      rx_data_d  = rx_sh_q;
      rx_valid_d = 1'b1;
      overrun_d  = rx_valid_q && !bus.rx_ready;
    end else if (rx_valid_q && bus.rx_ready) begin
      rx_valid_d = 1'b0;
    end
  end

  assign bus.busy        = ~ss_sync;
  assign bus.miso_oe     = ~ss_sync;
  assign bus.miso_out    = (state_q == ACTIVE) && !ss_sync &&
                           (lsbfe_q ? tx_sh_q[0] : tx_sh_q[DATA_W-1]);
  assign bus.tx_ready    = ~tx_full_q;
  assign bus.rx_data     = rx_data_q;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.overrun     = overrun_q;
  assign bus.frame_abort = abort_q;

endmodule

// File: tb/tb_spi_slave_core.sv
// Directed bench for spi_slave_core: a behavioural SPI master drives the pins
// at sclk = PCLK/8 and each scenario task checks against hand-computed values.
module tb_spi_slave_core;
  import spi_pkg::*;

  localparam int HALF = 4;

  logic PCLK = 1'b0;
  logic PRESET;
  int   checks = 0;
  int   fails  = 0;
  int   ov_cnt = 0;
  int   ab_cnt = 0;
  bit   txr_low_seen = 1'b0;

  spi_slave_core_if #(.DATA_W(8)) bus ();

  spi_slave_core #(.DATA_W(8), .SYNC_STAGES(2), .IDLE_TX(8'hFF)) dut (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .bus    (bus.slave)
  );

  always #5 PCLK = ~PCLK;

  always @(negedge PCLK) begin
    if (bus.overrun === 1'b1) ov_cnt++;
    if (bus.frame_abort === 1'b1) ab_cnt++;
    if (bus.tx_ready !== 1'b1) txr_low_seen = 1'b1;
  end

  task automatic set_mode(input logic [1:0] mode, input logic lsb);
    @(negedge PCLK);
    bus.cpol    = mode[1];
    bus.cpha    = mode[0];
    bus.lsbfe   = lsb;
    bus.sclk_in = mode[1];
    repeat (HALF) @(negedge PCLK);
  endtask

  task automatic load_tx(input logic [7:0] d);
    @(negedge PCLK);
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    @(negedge PCLK);
    bus.tx_valid = 1'b0;
  endtask

  task automatic consume_rx();
    @(negedge PCLK);
    bus.rx_ready = 1'b1;
    @(negedge PCLK);
    bus.rx_ready = 1'b0;
  endtask

  // Master side of one frame; lat = first cycle rx_valid seen high after a sample edge
  task automatic spi_frame(input logic [7:0] mo, input int nbits, input bit keep_ss,
                           output logic [7:0] mi, output int lat);
    logic c_pha, c_lsb;
    int   bi;
    c_pha = bus.cpha;
    c_lsb = bus.lsbfe;
    mi  = 8'h00;
    lat = -1;
    bus.ss_n_in = 1'b0;
    if (!c_pha) bus.mosi_in = c_lsb ? mo[0] : mo[7];
    repeat (HALF) @(negedge PCLK);
    for (int i = 0; i < nbits; i++) begin
      bi = c_lsb ? i : 7 - i;
      if (c_pha) begin
        bus.sclk_in = ~bus.sclk_in;
        bus.mosi_in = mo[bi];
        repeat (HALF) @(negedge PCLK);
      end
      mi[bi] = bus.miso_out;
      bus.sclk_in = ~bus.sclk_in;
      for (int k = 1; k <= HALF; k++) begin
        @(negedge PCLK);
        if (lat < 0 && bus.rx_valid === 1'b1) lat = k;
      end
      if (!c_pha) begin
        bus.sclk_in = ~bus.sclk_in;
        if (i + 1 < nbits) bus.mosi_in = c_lsb ? mo[i + 1] : mo[6 - i];
        repeat (HALF) @(negedge PCLK);
      end
    end
    if (!keep_ss) begin
      bus.ss_n_in = 1'b1;
      repeat (HALF) @(negedge PCLK);
    end
  endtask

  task automatic test_reset();
    PRESET = 1'b1;
    repeat (4) @(negedge PCLK);
    checks++; if (bus.miso_out !== 1'b0) begin fails++; $display("FAIL reset_miso_out got=%b exp=0", bus.miso_out); end
    checks++; if (bus.miso_oe !== 1'b0) begin fails++; $display("FAIL reset_miso_oe got=%b exp=0", bus.miso_oe); end
    checks++; if (bus.tx_ready !== 1'b1) begin fails++; $display("FAIL reset_tx_ready got=%b exp=1", bus.tx_ready); end
    checks++; if (bus.rx_data !== 8'h00) begin fails++; $display("FAIL reset_rx_data got=%h exp=00", bus.rx_data); end
    checks++; if (bus.rx_valid !== 1'b0) begin fails++; $display("FAIL reset_rx_valid got=%b exp=0", bus.rx_valid); end
    checks++; if (bus.overrun !== 1'b0) begin fails++; $display("FAIL reset_overrun got=%b exp=0", bus.overrun); end
    checks++; if (bus.frame_abort !== 1'b0) begin fails++; $display("FAIL reset_frame_abort got=%b exp=0", bus.frame_abort); end
    checks++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    PRESET = 1'b0;
    repeat (4) @(negedge PCLK);
  endtask

  task automatic test_mode0();
    logic [7:0] mi;
    int lat;
    set_mode(MODE0, 1'b0);
    load_tx(8'hA5);
    checks++; if (bus.tx_ready !== 1'b0) begin fails++; $display("FAIL m0_tx_ready_loaded got=%b exp=0", bus.tx_ready); end
    spi_frame(8'h3C, 8, 1'b0, mi, lat);
    checks++; if (mi !== 8'hA5) begin fails++; $display("FAIL m0_miso got=%h exp=a5", mi); end
    checks++; if (bus.rx_data !== 8'h3C) begin fails++; $display("FAIL m0_rx_data got=%h exp=3c", bus.rx_data); end
    checks++; if (bus.rx_valid !== 1'b1) begin fails++; $display("FAIL m0_rx_valid got=%b exp=1", bus.rx_valid); end
    checks++; if (lat !== 4) begin fails++; $display("FAIL m0_rx_latency got=%0d exp=4", lat); end
    checks++; if (bus.tx_ready !== 1'b1) begin fails++; $display("FAIL m0_tx_ready_after got=%b exp=1", bus.tx_ready); end
    checks++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL m0_busy_after got=%b exp=0", bus.busy); end
    consume_rx();
    checks++; if (bus.rx_valid !== 1'b0) begin fails++; $display("FAIL m0_rx_consumed got=%b exp=0", bus.rx_valid); end
  endtask

  task automatic test_mode3_lsb();
    logic [7:0] mi;
    int lat;
    set_mode(MODE3, 1'b1);
    load_tx(8'h81);
    spi_frame(8'h01, 8, 1'b0, mi, lat);
    checks++; if (mi !== 8'h81) begin fails++; $display("FAIL m3_miso got=%h exp=81", mi); end
    checks++; if (bus.rx_data !== 8'h01) begin fails++; $display("FAIL m3_rx_data got=%h exp=01", bus.rx_data); end
    checks++; if (bus.rx_valid !== 1'b1) begin fails++; $display("FAIL m3_rx_valid got=%b exp=1", bus.rx_valid); end
    consume_rx();
  endtask

  task automatic test_back_to_back();
    logic [7:0] mi1, mi2;
    int lat;
    set_mode(MODE1, 1'b0);
    ov_cnt = 0;
    load_tx(8'h11);
    spi_frame(8'h5A, 8, 1'b1, mi1, lat);
    checks++; if (bus.rx_data !== 8'h5A) begin fails++; $display("FAIL b2b_rx_first got=%h exp=5a", bus.rx_data); end
    load_tx(8'h22);
    spi_frame(8'hC3, 8, 1'b0, mi2, lat);
    checks++; if (mi1 !== 8'h11) begin fails++; $display("FAIL b2b_miso_first got=%h exp=11", mi1); end
    checks++; if (mi2 !== 8'h22) begin fails++; $display("FAIL b2b_miso_second got=%h exp=22", mi2); end
    checks++; if (bus.rx_data !== 8'hC3) begin fails++; $display("FAIL b2b_rx_second got=%h exp=c3", bus.rx_data); end
    checks++; if (bus.rx_valid !== 1'b1) begin fails++; $display("FAIL b2b_rx_valid got=%b exp=1", bus.rx_valid); end
    checks++; if (ov_cnt !== 1) begin fails++; $display("FAIL b2b_overrun_pulses got=%0d exp=1", ov_cnt); end
    consume_rx();
  endtask

  task automatic test_empty_tx();
    logic [7:0] mi;
    int lat;
    set_mode(MODE2, 1'b0);
    txr_low_seen = 1'b0;
    spi_frame(8'h96, 8, 1'b0, mi, lat);
    checks++; if (mi !== 8'hFF) begin fails++; $display("FAIL m2_idle_miso got=%h exp=ff", mi); end
    checks++; if (bus.rx_data !== 8'h96) begin fails++; $display("FAIL m2_rx_data got=%h exp=96", bus.rx_data); end
    checks++; if (txr_low_seen !== 1'b0) begin fails++; $display("FAIL m2_tx_ready_dropped got=%b exp=0", txr_low_seen); end
    consume_rx();
  endtask

  task automatic test_abort();
    logic [7:0] mi;
    int lat;
    set_mode(MODE0, 1'b0);
    ab_cnt = 0;
    spi_frame(8'hF0, 5, 1'b0, mi, lat);
    checks++; if (ab_cnt !== 1) begin fails++; $display("FAIL abort_pulses got=%0d exp=1", ab_cnt); end
    checks++; if (bus.rx_valid !== 1'b0) begin fails++; $display("FAIL abort_rx_valid got=%b exp=0", bus.rx_valid); end
    checks++; if (bus.miso_oe !== 1'b0) begin fails++; $display("FAIL abort_miso_oe got=%b exp=0", bus.miso_oe); end
    spi_frame(8'h6B, 8, 1'b0, mi, lat);
    checks++; if (bus.rx_data !== 8'h6B) begin fails++; $display("FAIL abort_next_rx got=%h exp=6b", bus.rx_data); end
    checks++; if (bus.rx_valid !== 1'b1) begin fails++; $display("FAIL abort_next_valid got=%b exp=1", bus.rx_valid); end
    checks++; if (mi !== 8'hFF) begin fails++; $display("FAIL abort_next_miso got=%h exp=ff", mi); end
    checks++; if (ab_cnt !== 1) begin fails++; $display("FAIL abort_next_no_abort got=%0d exp=1", ab_cnt); end
    consume_rx();
  endtask

  task automatic test_reset_midframe();
    logic [7:0] mi;
    int lat;
    set_mode(MODE0, 1'b0);
    ab_cnt = 0;
    load_tx(8'h5C);
    spi_frame(8'hAA, 3, 1'b1, mi, lat);
    load_tx(8'h77);
    checks++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL rst_mid_busy_before got=%b exp=1", bus.busy); end
    checks++; if (bus.tx_ready !== 1'b0) begin fails++; $display("FAIL rst_mid_tx_full got=%b exp=0", bus.tx_ready); end
    PRESET = 1'b1;
    @(negedge PCLK);
    checks++; if (bus.miso_oe !== 1'b0) begin fails++; $display("FAIL rst_mid_miso_oe got=%b exp=0", bus.miso_oe); end
    checks++; if (bus.miso_out !== 1'b0) begin fails++; $display("FAIL rst_mid_miso_out got=%b exp=0", bus.miso_out); end
    checks++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL rst_mid_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.tx_ready !== 1'b1) begin fails++; $display("FAIL rst_mid_tx_ready got=%b exp=1", bus.tx_ready); end
    checks++; if (bus.rx_data !== 8'h00) begin fails++; $display("FAIL rst_mid_rx_data got=%h exp=00", bus.rx_data); end
    bus.ss_n_in = 1'b1;
    bus.sclk_in = 1'b0;
    repeat (3) @(negedge PCLK);
    PRESET = 1'b0;
    repeat (HALF) @(negedge PCLK);
    checks++; if (ab_cnt !== 0) begin fails++; $display("FAIL rst_mid_abort got=%0d exp=0", ab_cnt); end
    load_tx(8'hE7);
    spi_frame(8'h18, 8, 1'b0, mi, lat);
    checks++; if (mi !== 8'hE7) begin fails++; $display("FAIL rst_mid_next_miso got=%h exp=e7", mi); end
    checks++; if (bus.rx_data !== 8'h18) begin fails++; $display("FAIL rst_mid_next_rx got=%h exp=18", bus.rx_data); end
    checks++; if (bus.rx_valid !== 1'b1) begin fails++; $display("FAIL rst_mid_next_valid got=%b exp=1", bus.rx_valid); end
    consume_rx();
  endtask

  initial begin
    PRESET       = 1'b1;
    bus.cpol     = 1'b0;
    bus.cpha     = 1'b0;
    bus.lsbfe    = 1'b0;
    bus.sclk_in  = 1'b0;
    bus.ss_n_in  = 1'b1;
    bus.mosi_in  = 1'b0;
    bus.tx_data  = 8'h00;
    bus.tx_valid = 1'b0;
    bus.rx_ready = 1'b0;
    test_reset();
    test_mode0();
    test_mode3_lsb();
    test_back_to_back();
    test_empty_tx();
    test_abort();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
